// File: rtl/network_interface_sched_if.sv
// Packet channel from the spike network interface toward the router.
// Latency: none (wires only).
// Backpressure: valid/ready; master holds pkt_valid/pkt_data stable until pkt_ready.
interface network_interface_sched_if #(
    parameter int ADDR_W = 12
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2*ADDR_W-1:0]   pkt_data;

    modport master (output pkt_valid, output pkt_data, input pkt_ready);
    modport slave  (input pkt_valid, input pkt_data, output pkt_ready);
endinterface

// File: rtl/network_interface_sched.sv
// Spike network interface: latches local spikes and walks a CSR table, emitting one
// {src, dst} packet per downstream connection. Latency: spike edge to pkt_valid = 2 cycles.
// Backpressure: packet held until pkt_ready; optional counters via macro SPIKE_COUNT_EN.
module network_interface_sched #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int MAX_CONN    = 32,
    parameter int PTR_W       = 6
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [NUM_NEURONS-1:0]  spike_in,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [PTR_W-1:0]        cfg_idx,
    input  logic [ADDR_W-1:0]       cfg_data,
    network_interface_sched_if.master pkt,
    output logic                    busy
`ifdef SPIKE_COUNT_EN
    ,
    output logic [PTR_W+3:0]        spike_count,
    output logic [15:0]             pkt_count
`endif
);

    // Tables are sized to the full index space so every PTR_W index is legal;
    // slots beyond the real table depth are never written and stay zero.
    localparam int                TAB_N = 2**PTR_W;
    localparam logic [PTR_W-1:0]  NN    = PTR_W'(NUM_NEURONS);
    localparam logic [PTR_W-1:0]  MC    = PTR_W'(MAX_CONN);
    localparam logic [PTR_W-1:0]  ONE   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

    logic [ADDR_W-1:0]       addr_tab [TAB_N];
    logic [PTR_W-1:0]        ptr_tab  [TAB_N];
    logic [ADDR_W-1:0]       ds_tab   [TAB_N];

    logic [NUM_NEURONS-1:0]  pending;
    logic [NUM_NEURONS-1:0]  pending_nxt;
    logic [NUM_NEURONS-1:0]  drop;
    state_t                  state;
    logic [PTR_W-1:0]        cur;
    logic [PTR_W-1:0]        jp;
    logic [PTR_W-1:0]        endp;
    logic                    valid_q;
    logic [2*ADDR_W-1:0]     data_q;

    logic [PTR_W-1:0]        sel_idx;
    logic [PTR_W-1:0]        sel_lo;
    logic [PTR_W-1:0]        sel_hi;
    logic [PTR_W-1:0]        sel_end;
    logic                    sel_skip;
    logic [PTR_W-1:0]        jp_nxt;
    logic                    last;
    logic                    fire;
    logic                    any_left;

    assign pkt.pkt_valid = valid_q;
    assign pkt.pkt_data  = data_q;
    assign busy          = (pending != '0) | (state != IDLE);

    // Config port: tables only change while the timestep is held in clear.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAB_N; k++) begin
                addr_tab[k] <= '0;
                ptr_tab[k]  <= '0;
                ds_tab[k]   <= '0;
            end
        end else if (cfg_we && clear) begin
            case (cfg_sel)
                2'd0: if (cfg_idx < NN)  addr_tab[cfg_idx] <= cfg_data;
                2'd1: if (cfg_idx <= NN) ptr_tab[cfg_idx]  <= cfg_data[PTR_W-1:0];
                2'd2: if (cfg_idx < MC)  ds_tab[cfg_idx]   <= cfg_data;
                default: ;
            endcase
        end
    end

    // Lowest pending neuron wins; descending loop so the last hit is the lowest index.
    always_comb begin
        sel_idx = '0;
        for (int k = NUM_NEURONS-1; k >= 0; k--) begin
            if (pending[k]) sel_idx = PTR_W'(k);
        end
    end

    // CSR row bounds for the selected neuron, clipped to the table depth.
    always_comb begin
        sel_lo   = ptr_tab[sel_idx];
        sel_hi   = ptr_tab[sel_idx + ONE];
        sel_end  = (sel_hi > MC) ? MC : sel_hi;
        sel_skip = (sel_lo >= sel_end);
        jp_nxt   = jp + ONE;
        last     = (jp_nxt == endp);
        fire     = valid_q & pkt.pkt_ready;
    end

    // Bit of pending retired this cycle; a same-cycle spike re-sets it below.
    always_comb begin
        drop = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (state == SCAN && pending != '0 && sel_skip && sel_idx == PTR_W'(k))
                drop[k] = 1'b1;
            if (state == SEND && fire && last && cur == PTR_W'(k))
                drop[k] = 1'b1;
        end
        pending_nxt = (pending & ~drop) | spike_in;
        any_left    = (pending_nxt != '0);
    end

    // Pending spike register: clear flushes, otherwise retire-then-set.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)     pending <= '0;
        else if (clear) pending <= '0;
        else            pending <= pending_nxt;
    end

    // Scheduler FSM with registered packet outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            jp      <= '0;
            endp    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != '0) state <= SCAN;
                end
                SCAN: begin
                    if (pending == '0) begin
                        state <= IDLE;
                    end else begin
                        cur  <= sel_idx;
                        jp   <= sel_lo;
                        endp <= sel_end;
                        if (sel_skip) begin
                            state <= any_left ? SCAN : IDLE;
                        end else begin
                            state   <= SEND;
                            valid_q <= 1'b1;
                            data_q  <= {addr_tab[sel_idx], ds_tab[sel_lo]};
                        end
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            state   <= any_left ? SCAN : IDLE;
                        end else begin
                            jp     <= jp_nxt;
                            data_q <= {addr_tab[cur], ds_tab[jp_nxt]};
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_COUNT_EN
    localparam logic [PTR_W+3:0] SC_ONE = (PTR_W+4)'(1);
    localparam logic [15:0]      PC_ONE = 16'd1;

    // Saturating activity counters, flushed with the timestep.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            spike_count <= '0;
            pkt_count   <= '0;
        end else if (clear) begin
            spike_count <= '0;
            pkt_count   <= '0;
        end else begin
            if (state == SCAN && pending != '0 && spike_count != '1)
                spike_count <= spike_count + SC_ONE;
            if (fire && pkt_count != '1)
                pkt_count <= pkt_count + PC_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_network_interface_sched.sv
module tb_network_interface_sched;

    localparam int NN  = 10;
    localparam int AW  = 12;
    localparam int MC  = 32;
    localparam int PW  = 6;

    logic           CLK;
    logic           rst_n;
    logic           clear;
    logic [NN-1:0]  spike_in;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [PW-1:0]  cfg_idx;
    logic [AW-1:0]  cfg_data;
    logic           busy;
`ifdef SPIKE_COUNT_EN
    logic [PW+3:0]  spike_count;
    logic [15:0]    pkt_count;
`endif

    network_interface_sched_if #(.ADDR_W(AW)) pif ();

    network_interface_sched #(
        .NUM_NEURONS(NN), .ADDR_W(AW), .MAX_CONN(MC), .PTR_W(PW)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clear    (clear),
        .spike_in (spike_in),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .pkt      (pif),
        .busy     (busy)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count (spike_count),
        .pkt_count   (pkt_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] got [$];
    logic [23:0] exp_q [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every accepted packet, sampled mid-cycle before the accepting edge.
    always @(negedge CLK) begin
        if (rst_n && !clear && pif.pkt_valid && pif.pkt_ready)
            got.push_back(pif.pkt_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [PW-1:0] idx,
                             input logic [AW-1:0] data, input logic clr);
        clear    = clr;
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_idx  = idx;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_pkts(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_pkt%0d", tag, i),
                (i < got.size()) ? {8'd0, got[i]} : 32'hFFFF_FFFF, {8'd0, exp_q[i]});
    endtask

    task automatic load_tables();
        for (int i = 0; i < NN; i++) cfg_write(2'd0, PW'(i), AW'(12'h100 + i), 1'b1);
        cfg_write(2'd1, 6'd0, 12'd0, 1'b1);
        cfg_write(2'd1, 6'd1, 12'd3, 1'b1);
        cfg_write(2'd1, 6'd2, 12'd3, 1'b1);
        for (int i = 3; i <= NN; i++) cfg_write(2'd1, PW'(i), 12'd5, 1'b1);
        for (int i = 0; i < 5; i++) cfg_write(2'd2, PW'(i), AW'(12'hA00 + i), 1'b1);
        // reserved selector: must not disturb anything
        cfg_write(2'd3, 6'd0, 12'hFFF, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b1; spike_in = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_idx = '0; cfg_data = '0;
        pif.pkt_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, pif.pkt_valid}, 32'd0);
        chk("rst_data", {8'd0, pif.pkt_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        load_tables();

        // Single neuron, latency and back-to-back packets
        pif.pkt_ready = 1'b1;
        got.delete();
        spike_in = 10'b0000000001;
        tick();                               // E0
        spike_in = '0;
        chk("t1_e0_valid", {31'd0, pif.pkt_valid}, 32'd0);
        chk("t1_e0_busy", {31'd0, busy}, 32'd1);
        tick();                               // E1: SCAN
        chk("t1_e1_valid", {31'd0, pif.pkt_valid}, 32'd0);
        tick();                               // E2
        chk("t1_e2_valid", {31'd0, pif.pkt_valid}, 32'd1);
        chk("t1_e2_data", {8'd0, pif.pkt_data}, 32'h100A00);
        tick();
        chk("t1_e3_data", {8'd0, pif.pkt_data}, 32'h100A01);
        tick();
        chk("t1_e4_data", {8'd0, pif.pkt_data}, 32'h100A02);
        tick();
        chk("t1_e5_valid", {31'd0, pif.pkt_valid}, 32'd0);
        chk("t1_e5_busy", {31'd0, busy}, 32'd0);
        exp_q = '{24'h100A00, 24'h100A01, 24'h100A02};
        check_pkts("t1");

        // Three neurons at once, middle one has no connections
        got.delete();
        spike_in = 10'b0000000111;
        tick();
        spike_in = '0;
        wait_idle("t2");
        exp_q = '{24'h100A00, 24'h100A01, 24'h100A02, 24'h102A03, 24'h102A04};
        check_pkts("t2");

        // Backpressure on the first packet
        got.delete();
        pif.pkt_ready = 1'b0;
        spike_in = 10'b0000000001;
        tick();
        spike_in = '0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_hold%0d_valid", i), {31'd0, pif.pkt_valid}, 32'd1);
            chk($sformatf("t3_hold%0d_data", i), {8'd0, pif.pkt_data}, 32'h100A00);
            tick();
        end
        pif.pkt_ready = 1'b1;
        wait_idle("t3");
        exp_q = '{24'h100A00, 24'h100A01, 24'h100A02};
        check_pkts("t3");

        // Clear in the middle of a burst drops the outstanding packet
        got.delete();
        spike_in = 10'b0000000001;
        tick();                               // E0
        spike_in = '0;
        tick();                               // E1
        tick();                               // E2: A00 valid
        tick();                               // E3: A00 accepted, A01 valid
        chk("t4_pre_data", {8'd0, pif.pkt_data}, 32'h100A01);
        clear = 1'b1;
        tick();
        chk("t4_clr_valid", {31'd0, pif.pkt_valid}, 32'd0);
        chk("t4_clr_busy", {31'd0, busy}, 32'd0);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_post_valid", {31'd0, pif.pkt_valid}, 32'd0);
        exp_q = '{24'h100A00};
        check_pkts("t4");

        // Writes with clear low must be ignored
        cfg_write(2'd2, 6'd0, 12'hFFF, 1'b0);
        cfg_write(2'd0, 6'd0, 12'h777, 1'b0);
        cfg_write(2'd1, 6'd1, 12'd0, 1'b0);
        got.delete();
        spike_in = 10'b0000000001;
        tick();
        spike_in = '0;
        wait_idle("t4r");
        exp_q = '{24'h100A00, 24'h100A01, 24'h100A02};
        check_pkts("t4r");

        // Re-spike on the cycle of the last handshake
        got.delete();
        spike_in = 10'b0000000001;
        tick();                               // E0
        spike_in = '0;
        for (int i = 0; i < 4; i++) tick();   // E1..E4
        spike_in = 10'b0000000001;
        tick();                               // E5: last packet accepted
        spike_in = '0;
        wait_idle("t5");
        exp_q = '{24'h100A00, 24'h100A01, 24'h100A02, 24'h100A00, 24'h100A01, 24'h100A02};
        check_pkts("t5");

`ifdef SPIKE_COUNT_EN
        // Activity counters over the three-neuron scenario
        clear = 1'b1;
        tick();
        clear = 1'b0;
        spike_in = 10'b0000000111;
        tick();
        spike_in = '0;
        wait_idle("t6");
        chk("t6_spike_count", {22'd0, spike_count}, 32'd3);
        chk("t6_pkt_count", {16'd0, pkt_count}, 32'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_spike_count_clr", {22'd0, spike_count}, 32'd0);
        chk("t6_pkt_count_clr", {16'd0, pkt_count}, 32'd0);
`endif

        // Asynchronous reset mid-burst
        spike_in = 10'b0000000001;
        tick();
        spike_in = '0;
        tick();
        tick();
        chk("t7_pre_valid", {31'd0, pif.pkt_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", {31'd0, pif.pkt_valid}, 32'd0);
        chk("t7_rst_data", {8'd0, pif.pkt_data}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        // Tables are zero: a spike finds no connections and no packet appears
        got.delete();
        spike_in = 10'b0000000001;
        tick();
        spike_in = '0;
        chk("t7_busy_after_spike", {31'd0, busy}, 32'd1);
        wait_idle("t7");
        exp_q.delete();
        check_pkts("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
